// File: rtl/apb_slv_mem.sv
// APB4 completer backed by a flop-based word memory.
// Supports programmable wait states, byte-lane write strobes, a privileged
// upper region, and a saturating error counter.
module apb_slv_mem #(
  parameter int APB_ADDR_WIDTH  = 32,
  parameter int APB_DATA_WIDTH  = 32,
  parameter int APB_STROB_WIDTH = APB_DATA_WIDTH / 8,
  parameter int MEM_DEPTH       = 64,
  parameter int PROT_BASE       = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 wait_cfg,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic [APB_ADDR_WIDTH-1:0]  PADDR,
  input  logic                       PWRITE,
  input  logic [APB_DATA_WIDTH-1:0]  PWDATA,
  input  logic [APB_STROB_WIDTH-1:0] PSTROB,
  input  logic [2:0]                 PPROT,
  output logic [APB_DATA_WIDTH-1:0]  PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [7:0]                 err_cnt
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int XW = APB_ADDR_WIDTH - 2;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nxt;

  logic [APB_DATA_WIDTH-1:0]  mem [MEM_DEPTH];
  logic [3:0]                 cnt;
  logic [IW-1:0]              r_idx;
  logic                       r_write;
  logic [APB_DATA_WIDTH-1:0]  r_wdata;
  logic [APB_STROB_WIDTH-1:0] r_strb;
  logic                       r_err;

  logic [XW-1:0]              idx_in;
  logic                       in_err;
  logic                       setup, complete, abort, raise;
  logic [IW-1:0]              rd_idx;
  logic                       rd_err, rd_write;
  logic [APB_DATA_WIDTH-1:0]  rd_word;

  // Only the privileged bit of PPROT carries meaning here.
  logic unused_prot;
  assign unused_prot = ^PPROT[2:1];

  // Decode the live setup-phase request and its error condition.
  always_comb begin
    idx_in = PADDR[APB_ADDR_WIDTH-1:2];
    in_err = (idx_in >= XW'(MEM_DEPTH))
          || (PADDR[1:0] != 2'b00)
          || (!PWRITE && (PSTROB != '0))
          || ((idx_in >= XW'(PROT_BASE)) && !PPROT[0]);
  end

  // Next-state logic and transfer event strobes.
  always_comb begin
    state_nxt = state;
    setup     = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    raise     = 1'b0;
    unique case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          setup     = 1'b1;
          raise     = (wait_cfg == 4'd0);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (PENABLE && PREADY) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else begin
          raise     = (cnt == 4'd1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-wait transfers respond straight from the setup-phase inputs;
  // otherwise the latched request is used when PREADY is raised.
  always_comb begin
    rd_idx   = setup ? idx_in[IW-1:0] : r_idx;
    rd_err   = setup ? in_err : r_err;
    rd_write = setup ? PWRITE : r_write;
    rd_word  = mem[rd_idx];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request latch, wait counter, response outputs, memory and error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_err   <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      err_cnt <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (setup) begin
        r_idx   <= idx_in[IW-1:0];
        r_write <= PWRITE;
        r_wdata <= PWDATA;
        r_strb  <= PSTROB;
        r_err   <= in_err;
        cnt     <= wait_cfg;
      end else if (abort) begin
        cnt <= '0;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (raise) begin
        PREADY  <= 1'b1;
        PSLVERR <= rd_err;
        if (!rd_write) PRDATA <= rd_err ? '0 : rd_word;
      end else if (complete || abort) begin
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
      end

      if (complete) begin
        if (r_err) begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (r_write) begin
          for (int unsigned b = 0; b < APB_STROB_WIDTH; b++)
            if (r_strb[b]) mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
